// File: rtl/cv_timing_gen_if.sv
// Signal bundle between cv_timing_gen (slave) and its controller/consumer (master).
// Sprite lookahead signals exist only when CV_TIMING_GEN_SP_LOOKAHEAD_EN is defined.
interface cv_timing_gen_if #(
    parameter int H_W     = 11,
    parameter int V_W     = 10,
    parameter int FRAME_W = 8
);
    logic               cs;
    logic [V_W-1:0]     line_cmp;
    logic               irq_en;
    logic               pix_en;
    logic               h_front;
    logic               h_sync;
    logic               h_back;
    logic               h_active;
    logic               h_end;
    logic [H_W-1:0]     h_count;
    logic               v_front;
    logic               v_sync;
    logic               v_back;
    logic               v_active;
    logic               v_end;
    logic [V_W-1:0]     v_count;
    logic               hsync_out;
    logic               vsync_out;
    logic [FRAME_W-1:0] frame_count;
    logic               line_irq;
`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
    logic [V_W-1:0]     sp_v_count;
    logic               sp_v_active;
`endif

    modport master (
        output cs, line_cmp, irq_en,
        input  pix_en, h_front, h_sync, h_back, h_active, h_end, h_count,
        input  v_front, v_sync, v_back, v_active, v_end, v_count,
        input  hsync_out, vsync_out, frame_count, line_irq
`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
        , input sp_v_count, sp_v_active
`endif
    );

    modport slave (
        input  cs, line_cmp, irq_en,
        output pix_en, h_front, h_sync, h_back, h_active, h_end, h_count,
        output v_front, v_sync, v_back, v_active, v_end, v_count,
        output hsync_out, vsync_out, frame_count, line_irq
`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
        , output sp_v_count, sp_v_active
`endif
    );
endinterface

// File: rtl/cv_timing_gen.sv
// Parametrised CRT/LCD video timing generator: porch/sync/active phases, counts, frame counter, line irq.
// Optional next-line lookahead for the sprite engine: define CV_TIMING_GEN_SP_LOOKAHEAD_EN.

// Rejects phase lengths that the configured counter widths cannot hold.
module cv_timing_gen_chk #(
    parameter int PIX_DIV  = 2,
    parameter int H_W      = 11,
    parameter int V_W      = 10,
    parameter int H_FRONT  = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600
) (
    input logic clk
);
    localparam longint H_RANGE = longint'(1) << H_W;
    localparam longint V_RANGE = longint'(1) << V_W;

    always @(posedge clk) begin
        assert (PIX_DIV >= 1)
            else $error("cv_timing_gen: PIX_DIV must be at least 1");
        assert (longint'(H_FRONT) <= H_RANGE && longint'(H_SYNC) <= H_RANGE &&
                longint'(H_BACK) <= H_RANGE && longint'(H_ACTIVE) <= H_RANGE)
            else $error("cv_timing_gen: horizontal count reaches 2^H_W");
        assert (longint'(V_FRONT) <= V_RANGE && longint'(V_SYNC) <= V_RANGE &&
                longint'(V_BACK) <= V_RANGE && longint'(V_ACTIVE) <= V_RANGE)
            else $error("cv_timing_gen: vertical count reaches 2^V_W");
    end
endmodule

module cv_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_W      = 11,
    parameter int V_W      = 10,
    parameter int H_FRONT  = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int FRAME_W  = 8
) (
    input logic         clk,
    input logic         reset,
    cv_timing_gen_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_FRONT, ST_SYNC, ST_BACK, ST_ACTIVE} phase_t;

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    phase_t             h_state_q, h_state_d, v_state_q, v_state_d;
    logic [H_W-1:0]     h_cnt_q, h_cnt_d;
    logic [V_W-1:0]     v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               run_s, tick_s, h_end_s, v_end_s;
    logic [V_W-1:0]     v_count_s;

    function automatic phase_t next_phase(input phase_t s);
        case (s)
            ST_IDLE:   return ST_FRONT;
            ST_FRONT:  return ST_SYNC;
            ST_SYNC:   return ST_BACK;
            ST_BACK:   return ST_ACTIVE;
            ST_ACTIVE: return ST_FRONT;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [H_W-1:0] h_last(input phase_t s);
        case (s)
            ST_FRONT:  return H_W'(H_FRONT - 1);
            ST_SYNC:   return H_W'(H_SYNC - 1);
            ST_BACK:   return H_W'(H_BACK - 1);
            ST_ACTIVE: return H_W'(H_ACTIVE - 1);
            default:   return {H_W{1'b0}};
        endcase
    endfunction

    function automatic logic [V_W-1:0] v_last(input phase_t s);
        case (s)
            ST_FRONT:  return V_W'(V_FRONT - 1);
            ST_SYNC:   return V_W'(V_SYNC - 1);
            ST_BACK:   return V_W'(V_BACK - 1);
            ST_ACTIVE: return V_W'(V_ACTIVE - 1);
            default:   return {V_W{1'b0}};
        endcase
    endfunction

    cv_timing_gen_chk #(
        .PIX_DIV(PIX_DIV), .H_W(H_W), .V_W(V_W),
        .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
        .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE)
    ) u_chk (
        .clk(clk)
    );

    // Strobes are gated by reset as well so that reset cycles look exactly like idle ones.
    assign run_s   = bus.cs & ~reset;
    assign tick_s  = run_s & (div_q == DIV_LAST);
    assign h_end_s = tick_s & (h_state_q == ST_ACTIVE) & (h_cnt_q == h_last(ST_ACTIVE));
    assign v_end_s = h_end_s & (v_state_q == ST_ACTIVE) & (v_cnt_q == v_last(ST_ACTIVE));

    // State registers; reset wins over cs, and either one returns everything to idle.
    always_ff @(posedge clk) begin
        if (reset || !bus.cs) begin
            div_q     <= {DIV_W{1'b0}};
            h_state_q <= ST_IDLE;
            v_state_q <= ST_IDLE;
            h_cnt_q   <= {H_W{1'b0}};
            v_cnt_q   <= {V_W{1'b0}};
            frame_q   <= {FRAME_W{1'b0}};
        end else begin
            div_q     <= div_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            frame_q   <= frame_d;
        end
    end

    // Next state: divider, horizontal FSM on tick, vertical FSM on h_end, frame count on v_end.
    always_comb begin
        div_d     = div_q;
        h_state_d = h_state_q;
        h_cnt_d   = h_cnt_q;
        v_state_d = v_state_q;
        v_cnt_d   = v_cnt_q;
        frame_d   = frame_q;

        if (run_s) begin
            div_d = (div_q == DIV_LAST) ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end

        if (tick_s && (h_state_q == ST_IDLE || h_cnt_q == h_last(h_state_q))) begin
            h_state_d = next_phase(h_state_q);
            h_cnt_d   = {H_W{1'b0}};
        end else if (tick_s) begin
            h_cnt_d = h_cnt_q + H_W'(1);
        end else begin
            h_cnt_d = h_cnt_q;
        end

        if (h_end_s && (v_state_q == ST_IDLE || v_cnt_q == v_last(v_state_q))) begin
            v_state_d = next_phase(v_state_q);
            v_cnt_d   = {V_W{1'b0}};
        end else if (h_end_s) begin
            v_cnt_d = v_cnt_q + V_W'(1);
        end else begin
            v_cnt_d = v_cnt_q;
        end

        if (v_end_s) begin
            frame_d = frame_q + FRAME_W'(1);
        end else begin
            frame_d = frame_q;
        end
    end

    assign v_count_s = (v_state_q == ST_ACTIVE) ? v_cnt_q : {V_W{1'b0}};

    assign bus.pix_en      = run_s & (div_q == {DIV_W{1'b0}});
    assign bus.h_front     = (h_state_q == ST_FRONT);
    assign bus.h_sync      = (h_state_q == ST_SYNC);
    assign bus.h_back      = (h_state_q == ST_BACK);
    assign bus.h_active    = (h_state_q == ST_ACTIVE) & (v_state_q == ST_ACTIVE);
    assign bus.h_end       = h_end_s;
    assign bus.h_count     = (h_state_q == ST_ACTIVE) ? h_cnt_q : {H_W{1'b0}};
    assign bus.v_front     = (v_state_q == ST_FRONT);
    assign bus.v_sync      = (v_state_q == ST_SYNC);
    assign bus.v_back      = (v_state_q == ST_BACK);
    assign bus.v_active    = (v_state_q == ST_ACTIVE);
    assign bus.v_end       = v_end_s;
    assign bus.v_count     = v_count_s;
    assign bus.hsync_out   = (h_state_q == ST_SYNC) ? HS_POL : ~HS_POL;
    assign bus.vsync_out   = (v_state_q == ST_SYNC) ? VS_POL : ~VS_POL;
    assign bus.frame_count = frame_q;
    assign bus.line_irq    = h_end_s & bus.irq_en & (v_state_q == ST_ACTIVE) &
                             (v_count_s == bus.line_cmp);

`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
    logic sp_last_back_s;

    // The sprite engine prepares line N+1 while line N is displayed.
    assign sp_last_back_s  = (v_state_q == ST_BACK) & (v_cnt_q == v_last(ST_BACK));
    assign bus.sp_v_active = sp_last_back_s |
                             ((v_state_q == ST_ACTIVE) & (v_cnt_q != v_last(ST_ACTIVE)));
    assign bus.sp_v_count  = sp_last_back_s ? {V_W{1'b0}} : v_count_s + V_W'(1);
`endif
endmodule

// File: tb/tb_cv_timing_gen.sv
// Directed self-checking bench for cv_timing_gen (PIX_DIV=2, H 2/3/4/8, V 1/2/2/4) plus a
// tiny PIX_DIV=1 instance with inverted sync polarity used for the frame counter wrap.
module tb_cv_timing_gen;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cv_timing_gen_if #(.H_W(11), .V_W(10), .FRAME_W(8)) bus ();
    cv_timing_gen_if #(.H_W(2), .V_W(2), .FRAME_W(2)) bus2 ();

    cv_timing_gen #(
        .PIX_DIV(2), .H_W(11), .V_W(10),
        .H_FRONT(2), .H_SYNC(3), .H_BACK(4), .H_ACTIVE(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4),
        .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(8)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    cv_timing_gen #(
        .PIX_DIV(1), .H_W(2), .V_W(2),
        .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .H_ACTIVE(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(2)
    ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_hs, n_vs, n_pix, n_hact, n_hend, n_vend, vend_at, n_irq, irq_bad;
    int max_hc, max_vc, sp_err, back_idx;
    bit found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return bus.v_end === 1'b1;
            1:       return bus.h_active === 1'b1;
            2:       return (bus.h_sync === 1'b1) && (bus.v_sync === 1'b1);
            3:       return bus2.v_end === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cond(which)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({"wait_", tag}, 64'(found), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_flags"}, 64'({bus.pix_en, bus.h_front, bus.h_sync, bus.h_back, bus.h_active,
             bus.h_end, bus.v_front, bus.v_sync, bus.v_back, bus.v_active, bus.v_end,
             bus.line_irq}), 64'd0);
        chk({tag, "_h_count"}, 64'(bus.h_count), 64'd0);
        chk({tag, "_v_count"}, 64'(bus.v_count), 64'd0);
        chk({tag, "_frame"}, 64'(bus.frame_count), 64'd0);
        chk({tag, "_hsync"}, 64'(bus.hsync_out), 64'd0);
        chk({tag, "_vsync"}, 64'(bus.vsync_out), 64'd0);
    endtask

    // Called at the negedge where reset or cs has just been released.
    task automatic restart_seq(input string tag);
        #1;
        chk({tag, "_pix_en0"}, 64'(bus.pix_en), 64'd1);
        chk({tag, "_front0"}, 64'(bus.h_front), 64'd0);
        step();
        chk({tag, "_pix_en1"}, 64'(bus.pix_en), 64'd0);
        chk({tag, "_front1"}, 64'(bus.h_front), 64'd0);
        step();
        chk({tag, "_pix_en2"}, 64'(bus.pix_en), 64'd1);
        chk({tag, "_front2"}, 64'(bus.h_front), 64'd1);
    endtask

    task automatic run_frame(input int exp_line);
        n_hs = 0; n_vs = 0; n_pix = 0; n_hact = 0; n_hend = 0; n_vend = 0;
        vend_at = -1; n_irq = 0; irq_bad = 0; max_hc = 0; max_vc = 0; sp_err = 0;
        for (int i = 1; i <= 306; i++) begin
            if (bus.hsync_out === 1'b1) n_hs++;
            if (bus.vsync_out === 1'b1) n_vs++;
            if (bus.pix_en === 1'b1) n_pix++;
            if (bus.h_active === 1'b1) n_hact++;
            if (bus.h_end === 1'b1) n_hend++;
            if (bus.v_end === 1'b1) begin
                n_vend++;
                vend_at = i;
            end
            if (int'(bus.h_count) > max_hc) max_hc = int'(bus.h_count);
            if (int'(bus.v_count) > max_vc) max_vc = int'(bus.v_count);
            if (bus.line_irq === 1'b1) begin
                n_irq++;
                if (!(bus.h_end === 1'b1 && int'(bus.v_count) == exp_line)) irq_bad++;
            end
`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
            if (bus.h_end === 1'b1) begin
                if (bus.v_sync === 1'b1) back_idx = 0;
                if (bus.v_back === 1'b1) begin
                    if (bus.sp_v_active !== (back_idx == 1)) sp_err++;
                    if (back_idx == 1 && bus.sp_v_count !== 10'd0) sp_err++;
                    back_idx++;
                end else if (bus.v_active === 1'b1) begin
                    if (bus.sp_v_active !== (int'(bus.v_count) != 3)) sp_err++;
                    if (int'(bus.v_count) != 3 && int'(bus.sp_v_count) != int'(bus.v_count) + 1)
                        sp_err++;
                end else if (bus.sp_v_active !== 1'b0) begin
                    sp_err++;
                end
            end
`endif
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cs = 1'b1;  bus.irq_en = 1'b0;  bus.line_cmp = 10'd0;
        bus2.cs = 1'b1; bus2.irq_en = 1'b0; bus2.line_cmp = 2'd0;
        back_idx = 0;

        repeat (3) step();
        check_idle("rst");
        reset = 1'b0;
        restart_seq("rst_rel");

        // cs dropped in the middle of an active pixel, after one frame has completed
        wait_for(0, "vend_a");
        step();
        wait_for(1, "hact");
        chk("pre_cs_frame", 64'(bus.frame_count), 64'd1);
        bus.cs = 1'b0;
        #1;
        chk("cs_off_pix_en", 64'(bus.pix_en), 64'd0);
        step();
        check_idle("cs_off");
        step();
        check_idle("cs_hold");
        bus.cs = 1'b1;
        restart_seq("cs_on");

        // reset pulse with cs high while both syncs are asserted
        wait_for(0, "vend_b");
        step();
        wait_for(2, "hvsync");
        chk("pre_rst_hsync", 64'(bus.hsync_out), 64'd1);
        chk("pre_rst_vsync", 64'(bus.vsync_out), 64'd1);
        reset = 1'b1;
        step();
        check_idle("rst_sync");
        reset = 1'b0;
        restart_seq("rst_sync_rel");

        // free run: one full frame measured between successive v_end pulses
        bus.line_cmp = 10'd2;
        bus.irq_en   = 1'b1;
        wait_for(0, "vend_c");
        chk("frame_at_vend0", 64'(bus.frame_count), 64'd0);
        step();
        chk("frame_after_vend0", 64'(bus.frame_count), 64'd1);
        run_frame(2);
        chk("hsync_clocks", 64'(n_hs), 64'd54);
        chk("vsync_clocks", 64'(n_vs), 64'd68);
        chk("pix_en_clocks", 64'(n_pix), 64'd153);
        chk("h_active_clocks", 64'(n_hact), 64'd64);
        chk("h_end_count", 64'(n_hend), 64'd9);
        chk("v_end_count", 64'(n_vend), 64'd1);
        chk("v_end_period", 64'(vend_at), 64'd306);
        chk("h_count_max", 64'(max_hc), 64'd7);
        chk("v_count_max", 64'(max_vc), 64'd3);
        chk("irq_cmp2_count", 64'(n_irq), 64'd1);
        chk("irq_cmp2_where", 64'(irq_bad), 64'd0);
        chk("frame_after_vend1", 64'(bus.frame_count), 64'd2);
`ifdef CV_TIMING_GEN_SP_LOOKAHEAD_EN
        chk("sp_lookahead", 64'(sp_err), 64'd0);
`endif

        bus.line_cmp = 10'd4;
        run_frame(4);
        chk("irq_cmp4_count", 64'(n_irq), 64'd0);

        bus.line_cmp = 10'd3;
        run_frame(3);
        chk("irq_cmp3_count", 64'(n_irq), 64'd1);
        chk("irq_cmp3_where", 64'(irq_bad), 64'd0);
        chk("frame_after_vend3", 64'(bus.frame_count), 64'd4);

        bus.line_cmp = 10'd2;
        bus.irq_en   = 1'b0;
        run_frame(2);
        chk("irq_disabled_count", 64'(n_irq), 64'd0);

        // tiny instance: inverted polarity idle levels, PIX_DIV=1, 2-bit frame counter wrap
        reset = 1'b1;
        step();
        chk("inv_idle_hsync", 64'(bus2.hsync_out), 64'd1);
        chk("inv_idle_vsync", 64'(bus2.vsync_out), 64'd1);
        chk("inv_idle_pix_en", 64'(bus2.pix_en), 64'd0);
        reset = 1'b0;
        #1;
        chk("div1_pix_en", 64'(bus2.pix_en), 64'd1);
        for (int k = 0; k < 4; k++) begin
            wait_for(3, "vend2");
            chk("wrap_frame_at_vend", 64'(bus2.frame_count), 64'(k));
            step();
        end
        chk("wrap_frame_zero", 64'(bus2.frame_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
